// File: rtl/cpu_cmd_sequencer.sv
// Host-side command sequencer: queues host commands, issues them to the CPU one at a time and
// returns each captured result. Build macro CPU_SEQ_STATS_EN adds saturating statistics counters.
module cpu_cmd_sequencer #(
   parameter int         WIDTH   = 8,
   parameter int         DEPTH   = 4,
   parameter int         TIMEOUT = 255,
   parameter logic [6:0] NOP_CMD = 7'd0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               host_valid,
   output logic               host_ready,
   input  logic [6:0]         host_cmd,
   input  logic [WIDTH-1:0]   host_d1,
   input  logic [WIDTH-1:0]   host_d2,
   input  logic [WIDTH-1:0]   host_d3,
   input  logic [WIDTH-1:0]   host_d4,
   output logic [6:0]         cmd_out,
   output logic [WIDTH-1:0]   dout_1,
   output logic [WIDTH-1:0]   dout_2,
   output logic [WIDTH-1:0]   dout_3,
   output logic [WIDTH-1:0]   dout_4,
   input  logic               cpu_rdy,
   input  logic [2*WIDTH-1:0] cpu_result,
   input  logic               cpu_zero,
   input  logic               cpu_error,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [2*WIDTH-1:0] res_data,
   output logic               res_zero,
   output logic               res_error,
   output logic               res_timeout,
   output logic               busy,
`ifdef CPU_SEQ_STATS_EN
   output logic [15:0]        stat_issued,
   output logic [15:0]        stat_errors,
   output logic [15:0]        stat_timeouts,
`endif
   output logic [2:0]         state_dbg
);
   // Handshakes: a transfer happens on a rising clk edge where valid && ready are both high;
   // res_valid and its payload stay stable until that edge.
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE   = 3'd1,
      S_WAIT    = 3'd2,
      S_SAMPLE  = 3'd3,
      S_CAPTURE = 3'd4
   } state_t;

   typedef struct packed {
      logic [6:0]       cmd;
      logic [WIDTH-1:0] d1;
      logic [WIDTH-1:0] d2;
      logic [WIDTH-1:0] d3;
      logic [WIDTH-1:0] d4;
   } entry_t;

   state_t          state_q, state_d;
   entry_t          mem [DEPTH];
   entry_t          iss_q;
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     count;
   logic [CW-1:0]   timer;
   logic            full, empty, push, pop;
   logic            tmo_hit, load_res, timer_last, to_q;

   assign full       = (count == (AW+1)'(DEPTH));
   assign empty      = (count == '0);
   assign host_ready = !full;
   assign push       = host_valid && !full;
   assign busy       = (state_q != S_IDLE) || !empty;
   assign state_dbg  = state_q;
   assign timer_last = (timer == CW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{cmd: host_cmd, d1: host_d1, d2: host_d2, d3: host_d3, d4: host_d4};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      pop      = 1'b0;
      tmo_hit  = 1'b0;
      load_res = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!empty && cpu_rdy) begin
               pop     = 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (!cpu_rdy) state_d = S_WAIT;
            else if (timer_last) begin
               tmo_hit = 1'b1;
               state_d = S_CAPTURE;
            end
         end
         S_WAIT: begin
            if (cpu_rdy) state_d = S_SAMPLE;
            else if (timer_last) begin
               tmo_hit = 1'b1;
               state_d = S_CAPTURE;
            end
         end
         S_SAMPLE: state_d = S_CAPTURE;
         S_CAPTURE: begin
            // A result still waiting for the host must not be overwritten.
            if (!res_valid || res_ready) begin
               load_res = 1'b1;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         iss_q <= '0;
         timer <= '0;
         to_q  <= 1'b0;
      end else begin
         if (pop) iss_q <= mem[rd_ptr];
         if (pop || (state_q == S_ISSUE && state_d == S_WAIT)) timer <= '0;
         else if ((state_q == S_ISSUE || state_q == S_WAIT) && timer != CW'(TIMEOUT))
            timer <= timer + 1'b1;
         if (state_d == S_CAPTURE && state_q != S_CAPTURE) to_q <= tmo_hit;
      end
   end

   assign cmd_out = (state_q == S_ISSUE) ? iss_q.cmd : NOP_CMD;
   always_comb begin
      dout_1 = '0;
      dout_2 = '0;
      dout_3 = '0;
      dout_4 = '0;
      if (state_q == S_ISSUE || state_q == S_WAIT) begin
         dout_1 = iss_q.d1;
         dout_2 = iss_q.d2;
         dout_3 = iss_q.d3;
         dout_4 = iss_q.d4;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         res_valid   <= 1'b0;
         res_data    <= '0;
         res_zero    <= 1'b0;
         res_error   <= 1'b0;
         res_timeout <= 1'b0;
      end else if (load_res) begin
         res_valid   <= 1'b1;
         res_data    <= to_q ? '0 : cpu_result;
         res_zero    <= to_q ? 1'b0 : cpu_zero;
         res_error   <= to_q ? 1'b1 : cpu_error;
         res_timeout <= to_q;
      end else if (res_valid && res_ready) begin
         res_valid <= 1'b0;
      end
   end

`ifdef CPU_SEQ_STATS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_issued   <= '0;
         stat_errors   <= '0;
         stat_timeouts <= '0;
      end else begin
         if (pop && stat_issued != 16'hFFFF) stat_issued <= stat_issued + 16'd1;
         if (load_res && !to_q && cpu_error && stat_errors != 16'hFFFF)
            stat_errors <= stat_errors + 16'd1;
         if (tmo_hit && stat_timeouts != 16'hFFFF) stat_timeouts <= stat_timeouts + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cpu_cmd_sequencer.sv
// Directed bench for cpu_cmd_sequencer: CPU responder model, transaction-level scoreboard
// and hand-computed checks for latency, back-pressure, timeout and reset.
module tb_cpu_cmd_sequencer;
   localparam int         DEPTH   = 4;
   localparam int         TMO     = 8;
   localparam logic [6:0] NOP     = 7'd0;
   localparam logic [2:0] ST_WAIT = 3'd2;
   localparam logic [2:0] ST_CAPT = 3'd4;

   typedef struct packed {
      logic [6:0] cmd;
      logic [7:0] d1;
      logic [7:0] d2;
      logic [7:0] d3;
      logic [7:0] d4;
   } ent_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        host_valid, host_ready;
   logic [6:0]  host_cmd, cmd_out;
   logic [7:0]  host_d1, host_d2, host_d3, host_d4;
   logic [7:0]  dout_1, dout_2, dout_3, dout_4;
   logic        cpu_rdy, cpu_zero, cpu_error;
   logic [15:0] cpu_result, res_data;
   logic        res_valid, res_ready, res_zero, res_error, res_timeout, busy;
   logic [2:0]  state_dbg;
`ifdef CPU_SEQ_STATS_EN
   logic [15:0] stat_issued, stat_errors, stat_timeouts;
`endif

   int n_vec = 0;
   int n_err = 0;

   // bench-side knobs for the CPU responder
   logic cpu_hold  = 1'b0;
   logic cpu_never = 1'b0;
   int   cpu_lat   = 3;

   cpu_cmd_sequencer #(.WIDTH(8), .DEPTH(DEPTH), .TIMEOUT(TMO), .NOP_CMD(NOP)) dut (
      .clk(clk), .reset(reset),
      .host_valid(host_valid), .host_ready(host_ready), .host_cmd(host_cmd),
      .host_d1(host_d1), .host_d2(host_d2), .host_d3(host_d3), .host_d4(host_d4),
      .cmd_out(cmd_out), .dout_1(dout_1), .dout_2(dout_2), .dout_3(dout_3), .dout_4(dout_4),
      .cpu_rdy(cpu_rdy), .cpu_result(cpu_result), .cpu_zero(cpu_zero), .cpu_error(cpu_error),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_zero(res_zero), .res_error(res_error), .res_timeout(res_timeout), .busy(busy),
`ifdef CPU_SEQ_STATS_EN
      .stat_issued(stat_issued), .stat_errors(stat_errors), .stat_timeouts(stat_timeouts),
`endif
      .state_dbg(state_dbg)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // ---------------- helpers ----------------
   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // CPU behaviour: {result[15:0], zero, error}
   function automatic logic [17:0] resp(input logic [6:0] c, input logic [7:0] a, b, x, y);
      logic [15:0] r;
      logic        e;
      e = 1'b0;
      case (c)
         7'h05:   r = 16'(a) + 16'(b);
         7'h06:   r = 16'(a) * 16'(b);
         7'h7F: begin r = 16'h0000; e = 1'b1; end
         default: r = {x, y};
      endcase
      return {r, (r == 16'h0000), e};
   endfunction

   // ---------------- CPU responder ----------------
   int          busy_cnt = 0;
   logic [17:0] pending;
   always @(negedge clk) begin
      #1;
      if (!reset) begin
         cpu_rdy  = !cpu_hold;
         busy_cnt = 0;
      end else if (cpu_hold) begin
         cpu_rdy  = 1'b0;
         busy_cnt = 0;
      end else if (busy_cnt > 0) begin
         busy_cnt--;
         if (busy_cnt == 0) begin
            cpu_rdy = 1'b1;
            {cpu_result, cpu_zero, cpu_error} = pending;
         end
      end else if (!cpu_rdy) begin
         cpu_rdy = 1'b1;
      end else if (cmd_out != NOP && !cpu_never) begin
         cpu_rdy  = 1'b0;
         busy_cnt = cpu_lat;
         pending  = resp(cmd_out, dout_1, dout_2, dout_3, dout_4);
      end
   end

   // ---------------- scoreboard ----------------
   ent_t        m_cmd_q[$];
   logic [18:0] exp_q[$];
   ent_t        cur;
   int          m_count = 0;
   logic        m_ready_prev = 1'b1;
   logic        prev_rv = 1'b0;
   logic [18:0] prev_res = '0;
   logic [18:0] cur_res;
   logic [6:0]  prev_cmd = NOP;

   always @(negedge clk) begin
      if (!reset) begin
         m_cmd_q.delete();
         exp_q.delete();
         m_count      = 0;
         m_ready_prev = 1'b1;
         prev_rv      = 1'b0;
         prev_res     = '0;
         prev_cmd     = NOP;
      end else begin
         if (host_valid && m_ready_prev) begin
            m_cmd_q.push_back('{cmd: host_cmd, d1: host_d1, d2: host_d2, d3: host_d3, d4: host_d4});
            m_count++;
         end
         if (cmd_out != NOP && prev_cmd == NOP) begin
            if (m_cmd_q.size() == 0) check("issue_unexpected", 32'(cmd_out), 32'(NOP));
            else begin
               cur = m_cmd_q.pop_front();
               m_count--;
               if (cpu_never) exp_q.push_back({16'h0000, 1'b0, 1'b1, 1'b1});
               else           exp_q.push_back({resp(cur.cmd, cur.d1, cur.d2, cur.d3, cur.d4), 1'b0});
            end
         end
         if (cmd_out != NOP) begin
            check("issue_cmd", 32'(cmd_out), 32'(cur.cmd));
            check("issue_ops", {dout_1, dout_2, dout_3, dout_4}, {cur.d1, cur.d2, cur.d3, cur.d4});
         end
         check("host_ready", 32'(host_ready), 32'(m_count < DEPTH));
         cur_res = {res_data, res_zero, res_error, res_timeout};
         if (prev_rv && res_ready) begin
            if (exp_q.size() == 0) check("res_unexpected", 32'(prev_rv), 32'd0);
            else                   check("res_payload", 32'(prev_res), 32'(exp_q.pop_front()));
         end else if (prev_rv) begin
            check("res_hold_valid", 32'(res_valid), 32'd1);
            check("res_hold_data", 32'(cur_res), 32'(prev_res));
         end
         prev_rv      = res_valid;
         prev_res     = cur_res;
         m_ready_prev = (m_count < DEPTH);
         prev_cmd     = cmd_out;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic push(input logic [6:0] c, input logic [7:0] a, b, x, y);
      host_valid = 1'b1;
      host_cmd   = c;
      host_d1    = a;
      host_d2    = b;
      host_d3    = x;
      host_d4    = y;
      tick();
      host_valid = 1'b0;
   endtask

   task automatic wait_res(input int max);
      for (int i = 0; i < max; i++) begin
         if (res_valid) break;
         tick();
      end
      check("wait_res", 32'(res_valid), 32'd1);
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      int n;
      reset      = 1'b0;
      host_valid = 1'b0;
      host_cmd   = '0;
      host_d1    = '0;
      host_d2    = '0;
      host_d3    = '0;
      host_d4    = '0;
      cpu_rdy    = 1'b1;
      cpu_result = '0;
      cpu_zero   = 1'b0;
      cpu_error  = 1'b0;
      res_ready  = 1'b0;
      repeat (3) tick();
      check("rst_host_ready", 32'(host_ready), 32'd1);
      check("rst_cmd_out", 32'(cmd_out), 32'(NOP));
      check("rst_dout", {dout_1, dout_2, dout_3, dout_4}, 32'd0);
      check("rst_res", {13'd0, res_valid, res_data, res_zero, res_error, res_timeout}, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_state", 32'(state_dbg), 32'd0);
      reset = 1'b1;
      tick();

      // basic command: 3 + 4 with a 3-cycle CPU busy period
      push(7'h05, 8'h03, 8'h04, 8'h00, 8'h00);
      check("lat_not_yet", 32'(cmd_out), 32'(NOP));
      tick();
      check("lat_issue", 32'(cmd_out), 32'h05);
      check("lat_ops", {dout_1, dout_2}, 32'h0304);
      wait_res(30);
      check("t1_data", 32'(res_data), 32'h0007);
      check("t1_flags", {res_zero, res_error, res_timeout}, 32'd0);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check("t1_consumed", 32'(res_valid), 32'd0);

      // queue fill while the CPU is busy
      cpu_hold = 1'b1;
      tick();
      tick();
      push(7'h05, 8'h01, 8'h02, 8'h00, 8'h00);
      push(7'h06, 8'h03, 8'h04, 8'h00, 8'h00);
      push(7'h10, 8'h00, 8'h00, 8'hAB, 8'hCD);
      push(7'h05, 8'h00, 8'h00, 8'h00, 8'h00);
      check("fill_full", 32'(host_ready), 32'd0);
      check("fill_busy", 32'(busy), 32'd1);
      push(7'h06, 8'h05, 8'h05, 8'h00, 8'h00);
      check("fill_still_full", 32'(host_ready), 32'd0);
      cpu_lat   = 1;
      res_ready = 1'b1;
      cpu_hold  = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (!busy && !res_valid && exp_q.size() == 0) break;
         tick();
      end
      check("fill_idle", 32'(busy), 32'd0);
      check("fill_delivered", 32'(exp_q.size()), 32'd0);

      // two completions held by res_ready=0
      res_ready = 1'b0;
      push(7'h05, 8'h0A, 8'h14, 8'h00, 8'h00);
      push(7'h06, 8'h02, 8'h03, 8'h00, 8'h00);
      wait_res(30);
      check("stall_first", 32'(res_data), 32'h001E);
      repeat (12) tick();
      check("stall_first_held", 32'(res_data), 32'h001E);
      check("stall_in_capture", 32'(state_dbg), 32'(ST_CAPT));
      res_ready = 1'b1;
      tick();
      check("stall_second_valid", 32'(res_valid), 32'd1);
      check("stall_second_data", 32'(res_data), 32'h0006);
      tick();
      check("stall_drained", 32'(res_valid), 32'd0);

      // CPU never accepts: timeout after TMO cycles in ISSUE
      cpu_never = 1'b1;
      push(7'h05, 8'h01, 8'h01, 8'h00, 8'h00);
      tick();
      n = 0;
      while (cmd_out != NOP && n < 40) begin
         n++;
         tick();
      end
      check("tmo_issue_cycles", 32'(n), 32'(TMO));
      cpu_never = 1'b0;
      wait_res(10);
      check("tmo_result", {res_data, res_zero, res_error, res_timeout}, 32'h0000_0003);
      push(7'h06, 8'h07, 8'h08, 8'h00, 8'h00);
      wait_res(30);
      check("tmo_next_cmd", {res_data, res_zero, res_error, res_timeout}, {16'h0038, 4'b0000} >> 1);

      // reset while a command is in WAIT and two are queued
      cpu_lat = 6;
      tick();
      push(7'h05, 8'h11, 8'h22, 8'h33, 8'h44);
      push(7'h06, 8'h01, 8'h01, 8'h00, 8'h00);
      push(7'h06, 8'h02, 8'h02, 8'h00, 8'h00);
      check("pre_rst_wait", 32'(state_dbg), 32'(ST_WAIT));
      check("pre_rst_ops", 32'(dout_1), 32'h11);
      #2;
      reset = 1'b0;
      #1;
      check("arst_cmd_out", 32'(cmd_out), 32'(NOP));
      check("arst_dout", {dout_1, dout_2, dout_3, dout_4}, 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_host_ready", 32'(host_ready), 32'd1);
      tick();
      tick();
      reset = 1'b1;
      repeat (20) tick();
      check("post_rst_no_stale", 32'(res_valid), 32'd0);
      check("post_rst_idle", {busy, cmd_out}, 32'd0);

      // zero and error flags from the CPU
      cpu_lat   = 2;
      res_ready = 1'b0;
      push(7'h7F, 8'h00, 8'h00, 8'h00, 8'h00);
      wait_res(30);
      check("zerr_flags", {res_data, res_zero, res_error, res_timeout}, 32'h0000_0006);
`ifdef CPU_SEQ_STATS_EN
      check("stat_issued", 32'(stat_issued), 32'd1);
      check("stat_errors", 32'(stat_errors), 32'd1);
      check("stat_timeouts", 32'(stat_timeouts), 32'd0);
`endif
      res_ready = 1'b1;
      repeat (3) tick();
      check("final_res_q", 32'(exp_q.size()), 32'd0);
      check("final_cmd_q", 32'(m_cmd_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cpu_cmd_sequencer.md
Name: cpu_cmd_sequencer

Overview:
Host-side driver for the CPU datapath. It queues commands (7-bit opcode plus four 8-bit operands) pushed by a host and issues them one at a time onto the CPU's cmd_in/din_1..din_4 inputs. It tracks the cpu_rdy handshake, captures the 16-bit result with its zero/error flags, and returns each result on a valid/ready output. It also bounds each transaction with a timeout.

Parameters:
WIDTH, 8, operand width; result width is 2*WIDTH
DEPTH, 4, command queue entries (power of 2, >=2)
TIMEOUT, 255, max cycles spent in ISSUE or WAIT before abort
NOP_CMD, 7'd0, value driven on cmd_out when no command is in flight

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
host_valid  in  1  host command push request
host_ready  out  1  queue not full
host_cmd  in  7  command opcode
host_d1..host_d4  in  WIDTH each  operands
cmd_out  out  7  to CPU cmd_in
dout_1..dout_4  out  WIDTH each  to CPU din_1..din_4
cpu_rdy  in  1  CPU ready/idle
cpu_result  in  2*WIDTH  from CPU out_reg3
cpu_zero  in  1  from CPU zero
cpu_error  in  1  from CPU error
res_valid  out  1  result available
res_ready  in  1  host accepts result
res_data  out  2*WIDTH  captured result
res_zero  out  1  captured zero
res_error  out  1  captured error
res_timeout  out  1  transaction aborted by timeout
busy  out  1  FSM not in IDLE, or queue not empty

Behaviour:
- Reset (reset=0, async) values:
  - FSM=IDLE; queue empty.
  - host_ready=1, cmd_out=NOP_CMD, dout_*=0.
  - res_valid=0, res_data=0, res_zero/res_error/res_timeout=0.
  - busy=0; timeout counter=0.
- Reset mid-transaction discards the queue and the in-flight result. cmd_out returns to NOP_CMD immediately (async).
- Queue: FIFO of DEPTH entries {cmd, d1..d4}.
  - Push when host_valid && host_ready.
  - host_ready = !full.
  - Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle when full: push is refused (host_ready=0 that cycle); pop proceeds.
  - Push and pop in the same cycle when empty: impossible; pop requires non-empty.
- FSM states:
  - IDLE: if queue non-empty and cpu_rdy=1, pop the head into the issue register, go to ISSUE. If cpu_rdy=0, stay in IDLE.
  - ISSUE:
    - Drive cmd_out/dout_* from the issue register and hold them.
    - cpu_rdy=0 seen (CPU accepted): go to WAIT.
    - Counter reaches TIMEOUT: go to CAPTURE with timeout=1.
  - WAIT:
    - Operands are still held; cmd_out=NOP_CMD.
    - cpu_rdy=1: go to SAMPLE.
    - Counter reaches TIMEOUT: go to CAPTURE with timeout=1.
  - SAMPLE: one-cycle delay for the CPU output register to settle. Then go to CAPTURE.
  - CAPTURE:
    - If res_valid=0, or res_valid && res_ready this cycle: load res_data/res_zero/res_error from the cpu_* inputs, set res_timeout, set res_valid=1, go to IDLE.
    - Otherwise stall in CAPTURE; the old result must not be overwritten.
    - On timeout: res_data=0, res_zero=0, res_error=1, res_timeout=1.
- Timeout counter: cleared on entry to ISSUE and to WAIT. Increments each cycle in those states and saturates at TIMEOUT.
- res_valid clears on res_valid && res_ready unless CAPTURE reloads in the same cycle (reload wins).
- Latency: push into an empty queue with the CPU idle → cmd_out valid 2 cycles later (push, then IDLE pop).
- Minimum turnaround per command: ISSUE 1 + WAIT 1 + SAMPLE 1 + CAPTURE 1 = 4 cycles.
- busy = (state != IDLE) || !empty.

Optional Feature:
CPU_SEQ_STATS_EN
- Defined: adds outputs stat_issued[15:0], stat_errors[15:0], stat_timeouts[15:0].
  - stat_issued increments on each ISSUE entry.
  - stat_errors increments on each CAPTURE load with cpu_error=1 and no timeout.
  - stat_timeouts increments on each timeout.
  - All three saturate at 16'hFFFF and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Push {cmd=7'h05, d1=8'h03, d2=8'h04}; CPU model drops cpu_rdy for 3 cycles, then returns cpu_result=16'h0007 → cmd_out=7'h05 until cpu_rdy falls; res_valid=1, res_data=16'h0007, res_zero=0, res_error=0, res_timeout=0.
- Push 5 commands with DEPTH=4 while cpu_rdy=0 → host_ready=0 after the 4th push, 5th refused; all 4 issued in order once cpu_rdy=1, results delivered in order.
- Hold res_ready=0 across two completions → first result held unchanged; FSM stalls in CAPTURE; second result appears the cycle after res_ready=1.
- CPU never drops cpu_rdy after issue (TIMEOUT=8) → after 8 cycles: res_valid=1, res_timeout=1, res_error=1, res_data=0; next command proceeds.
- Assert reset=0 during WAIT with 2 commands queued → cmd_out=NOP_CMD asynchronously; res_valid=0, busy=0, host_ready=1 after release; no stale result is delivered.
- CPU returns cpu_zero=1, cpu_error=1 → res_zero=1, res_error=1, res_timeout=0; with CPU_SEQ_STATS_EN: stat_errors=1, stat_issued=1.
